// File: rtl/wb_port_arbiter_if.sv
// Register-file write-port bundle: pipeline writeback, long-latency
// result handshake and the single register-file write port.
interface wb_port_arbiter_if;
  logic        pipe_rd_en;
  logic [4:0]  pipe_rd;
  logic [63:0] pipe_result;
  logic        pipe_stall;

  logic        ll_valid;
  logic        ll_ready;
  logic [4:0]  ll_rd;
  logic [63:0] ll_result;

  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [63:0] rf_wdata;

  modport master (
    output pipe_rd_en, pipe_rd, pipe_result,
    output ll_valid, ll_rd, ll_result,
    input  pipe_stall, ll_ready,
    input  rf_we, rf_rd, rf_wdata
  );

  modport slave (
    input  pipe_rd_en, pipe_rd, pipe_result,
    input  ll_valid, ll_rd, ll_result,
    output pipe_stall, ll_ready,
    output rf_we, rf_rd, rf_wdata
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between the pipeline and a
// 2-entry buffer of long-latency results with a starvation guard.
module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic             clk,
  input logic             rst,
  wb_port_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

  logic [4:0]    q_rd   [2];
  logic [63:0]   q_data [2];
  logic          rd_ptr;
  logic          wr_ptr;
  logic [1:0]    count;
  logic [SW-1:0] starve;

  logic        ll_ready;
  logic        ll_keep;
  logic        force_drain;
  logic        pipe_wr;
  logic        pop;
  logic        bypass;
  logic        push;
  logic        we;
  logic [4:0]  wrd;
  logic [63:0] wdata;

  assign ll_ready = (count < 2'd2);

  // Nothing is selected during reset so buffered entries are never written.
  always_comb begin
    ll_keep     = bus.ll_valid && ll_ready
                  && (bus.ll_rd != 5'd0) && !rst;
    force_drain = !rst && (count != 2'd0) && (starve == LIM);
    pipe_wr     = !rst && !force_drain && bus.pipe_rd_en
                  && (bus.pipe_rd != 5'd0);
    pop         = !rst && (count != 2'd0)
                  && (force_drain || !pipe_wr);
    bypass      = (count == 2'd0) && !pipe_wr && ll_keep;
    push        = ll_keep && !bypass;
  end

  always_comb begin
    we    = 1'b0;
    wrd   = 5'd0;
    wdata = 64'd0;
    unique case (1'b1)
      pop: begin
        we    = 1'b1;
        wrd   = q_rd[rd_ptr];
        wdata = q_data[rd_ptr];
      end
      pipe_wr: begin
        we    = 1'b1;
        wrd   = bus.pipe_rd;
        wdata = bus.pipe_result;
      end
      bypass: begin
        we    = 1'b1;
        wrd   = bus.ll_rd;
        wdata = bus.ll_result;
      end
      default: ;
    endcase
  end

  assign bus.ll_ready   = ll_ready;
  assign bus.pipe_stall = force_drain;
  assign bus.rf_we      = we;
  assign bus.rf_rd      = wrd;
  assign bus.rf_wdata   = wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      starve <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
      if (pop || (count == 2'd0)) begin
        starve <= '0;
      end else if (starve != LIM) begin
        starve <= starve + SW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr]   <= bus.ll_rd;
      q_data[wr_ptr] <= bus.ll_result;
    end
  end
endmodule
